// File: rtl/watchdog_pkg.sv
// Shared definitions for the coefficient loader: FSM encoding, default
// parameter values and the chunk ordering used when assembling coefficients.
package watchdog_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam int NUM_COEF_DEF = 2;
  localparam int COEF_W_DEF   = 32;
  localparam int IN_W_DEF     = 8;
  localparam int BUSY_TO_DEF  = 15;

  // First chunk of a coefficient lands in its least significant bits.
  localparam bit CHUNK_LSB_FIRST = 1'b1;

endpackage

// File: rtl/param_loader_n_assembler.sv
// Frame assembler: tracks chunk/coefficient position of the open frame and
// writes accepted chunks into the shadow buffer. Flags frame completion and
// restarts caused by a start-of-frame arriving while a frame is open.
module param_assembler
  import watchdog_pkg::*;
#(
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int IN_W     = IN_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       acc_i,
  input  logic                       sof_i,
  input  logic [IN_W-1:0]            data_i,
  output logic [NUM_COEF*COEF_W-1:0] shadow_o,
  output logic                       done_o,
  output logic                       restart_o
);

  localparam int CHUNKS = COEF_W / IN_W;
  localparam int CW     = $clog2(CHUNKS + 1);
  localparam int KW     = $clog2(NUM_COEF + 1);
  localparam int PW     = $clog2(NUM_COEF * COEF_W + 1);

  logic                       open_q, open_d;
  logic [CW-1:0]              chunk_q, chunk_d;
  logic [KW-1:0]              idx_q, idx_d;
  logic                       wr_en;
  logic [CW-1:0]              wr_chunk;
  logic [KW-1:0]              wr_idx;
  logic [CW-1:0]              lane;
  logic [PW-1:0]              pos;
  logic [NUM_COEF*COEF_W-1:0] shadow_q;

  // Decide where the current chunk goes and how the frame position advances.
  // A start-of-frame chunk always restarts at coefficient 0, chunk 0.
  always_comb begin
    wr_en     = acc_i && (sof_i || open_q);
    wr_chunk  = sof_i ? '0 : chunk_q;
    wr_idx    = sof_i ? '0 : idx_q;
    lane      = CHUNK_LSB_FIRST ? wr_chunk : (CW'(CHUNKS - 1) - wr_chunk);
    pos       = PW'(int'(wr_idx) * COEF_W + int'(lane) * IN_W);
    done_o    = wr_en && (wr_chunk == CW'(CHUNKS - 1)) && (wr_idx == KW'(NUM_COEF - 1));
    restart_o = acc_i && sof_i && open_q;
    open_d    = open_q;
    chunk_d   = chunk_q;
    idx_d     = idx_q;
    if (wr_en) begin
      if (done_o) begin
        open_d  = 1'b0;
        chunk_d = '0;
        idx_d   = '0;
      end else if (wr_chunk == CW'(CHUNKS - 1)) begin
        open_d  = 1'b1;
        chunk_d = '0;
        idx_d   = wr_idx + KW'(1);
      end else begin
        open_d  = 1'b1;
        chunk_d = wr_chunk + CW'(1);
        idx_d   = wr_idx;
      end
    end
  end

  // Frame position registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_q  <= 1'b0;
      chunk_q <= '0;
      idx_q   <= '0;
    end else begin
      open_q  <= open_d;
      chunk_q <= chunk_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow buffer write; contents are only meaningful once a frame completes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_q[pos +: IN_W] <= data_i;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/param_loader_n.sv
// Coefficient loader: double-buffers incoming coefficient frames and hands
// them to a compute core with a start pulse / busy handshake.
module param_loader_n
  import watchdog_pkg::*;
#(
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int IN_W     = IN_W_DEF,
  parameter int BUSY_TO  = BUSY_TO_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       in_sof,
  output logic                       in_ready,
  output logic [NUM_COEF*COEF_W-1:0] coef,
  output logic                       start_calc,
  input  logic                       core_busy,
  output logic                       load_err
);

  localparam int TW = $clog2(BUSY_TO + 1) + 1;

  state_t                     state_q, state_d;
  logic                       pending_q, pending_d;
  logic [NUM_COEF*COEF_W-1:0] coef_q, coef_d;
  logic                       start_q, start_d;
  logic                       err_q, err_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       tmo_err;
  logic                       accept;
  logic [NUM_COEF*COEF_W-1:0] shadow;
  logic                       asm_done;
  logic                       asm_restart;

  // A full shadow frame blocks further input until it has been committed.
  assign in_ready = !pending_q;
  assign accept   = in_valid && in_ready;

  param_assembler #(
    .NUM_COEF (NUM_COEF),
    .COEF_W   (COEF_W),
    .IN_W     (IN_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .acc_i     (accept),
    .sof_i     (in_sof),
    .data_i    (in_data),
    .shadow_o  (shadow),
    .done_o    (asm_done),
    .restart_o (asm_restart)
  );

  // Handshake FSM: commit the pending frame when the core is idle, then
  // wait for busy to rise (bounded) and fall before the next commit.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    coef_d    = coef_q;
    start_d   = 1'b0;
    tmo_d     = tmo_q;
    tmo_err   = 1'b0;
    if (asm_done) begin
      pending_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (pending_q && !core_busy) begin
          coef_d    = shadow;
          pending_d = 1'b0;
          start_d   = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // tmo_q counts waiting cycles already spent; give up after BUSY_TO.
        if (core_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TO - 1)) begin
          tmo_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!core_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = asm_restart || tmo_err;
  end

  // State, buffers and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      coef_q    <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      coef_q    <= coef_d;
      start_q   <= start_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign coef       = coef_q;
  assign start_calc = start_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_param_loader_n.sv
// Directed bench for param_loader_n with the default 2 x 32-bit / 8-bit setup.
module tb_param_loader_n;

  localparam int NUM_COEF = 2;
  localparam int COEF_W   = 32;
  localparam int IN_W     = 8;
  localparam int BUSY_TO  = 15;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [IN_W-1:0]            in_data;
  logic                       in_valid;
  logic                       in_sof;
  logic                       in_ready;
  logic [NUM_COEF*COEF_W-1:0] coef;
  logic                       start_calc;
  logic                       core_busy;
  logic                       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [0:7][7:0] ch;
    logic [31:0]     c0;
    logic [31:0]     c1;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  param_loader_n #(
    .NUM_COEF (NUM_COEF),
    .COEF_W   (COEF_W),
    .IN_W     (IN_W),
    .BUSY_TO  (BUSY_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .coef       (coef),
    .start_calc (start_calc),
    .core_busy  (core_busy),
    .load_err   (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [0:7][7:0] ch);
    for (int i = 0; i < 8; i++) send(ch[i], (i == 0));
  endtask

  // Core model: busy for n cycles starting in the start_calc cycle.
  task automatic run_core(input int n);
    core_busy = 1'b1;
    tick();
    chk("start_single_cycle", start_calc, 1'b0);
    repeat (n - 1) tick();
    core_busy = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0].ch = {8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hFF, 8'hFF, 8'hFF};
    vecs[0].c0 = 32'h12345678;  vecs[0].c1 = 32'hFFFFFFF0;
    vecs[1].ch = {8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    vecs[1].c0 = 32'h80000000;  vecs[1].c1 = 32'h7FFFFFFF;
    vecs[2].ch = {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
    vecs[2].c0 = 32'hDEADBEEF;  vecs[2].c1 = 32'h00000001;
    vecs[3].ch = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    vecs[3].c0 = 32'h04030201;  vecs[3].c1 = 32'hFFFFFFFE;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; core_busy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_coef", coef, 64'h0);
    chk("rst_start", start_calc, 1'b0);
    chk("rst_load_err", load_err, 1'b0);

    // Chunk without start-of-frame while idle is dropped silently.
    send(8'h55, 1'b0);
    chk("drop_in_ready", in_ready, 1'b1);
    chk("drop_load_err", load_err, 1'b0);
    tick();
    chk("drop_no_start", start_calc, 1'b0);

    // Table-driven frames with the core idle.
    for (int v = 0; v < 4; v++) begin
      chk("vec_ready_before", in_ready, 1'b1);
      send_frame(vecs[v].ch);
      chk("vec_start_lat1", start_calc, 1'b0);
      chk("vec_ready_pending", in_ready, 1'b0);
      tick();
      chk("vec_start_lat2", start_calc, 1'b1);
      chk("vec_coef0", coef[31:0], vecs[v].c0);
      chk("vec_coef1", coef[63:32], vecs[v].c1);
      chk("vec_no_err", load_err, 1'b0);
      run_core(4);
    end

    // Double buffering: second frame loads while the core is busy.
    send_frame(vecs[0].ch);
    tick();
    chk("db_start_a", start_calc, 1'b1);
    core_busy = 1'b1;
    tick();
    send_frame(vecs[1].ch);
    chk("db_ready_blocked", in_ready, 1'b0);
    chk("db_coef_held", coef[31:0], vecs[0].c0);
    chk("db_no_start_busy", start_calc, 1'b0);
    repeat (11) tick();
    core_busy = 1'b0;
    chk("db_fall0_start", start_calc, 1'b0);
    tick();
    chk("db_fall1_start", start_calc, 1'b0);
    chk("db_fall1_coef", coef[31:0], vecs[0].c0);
    tick();
    chk("db_fall2_start", start_calc, 1'b1);
    chk("db_coef0_b", coef[31:0], vecs[1].c0);
    chk("db_coef1_b", coef[63:32], vecs[1].c1);
    chk("db_ready_free", in_ready, 1'b1);
    run_core(3);

    // Start-of-frame on the 4th chunk restarts the frame.
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hEF, 1'b1);
    chk("rs_err_pulse", load_err, 1'b1);
    send(8'hBE, 1'b0);
    chk("rs_err_clear", load_err, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hDE, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    chk("rs_not_done_ready", in_ready, 1'b1);
    chk("rs_not_done_start", start_calc, 1'b0);
    send(8'h00, 1'b0);
    chk("rs_done_start_lat1", start_calc, 1'b0);
    chk("rs_done_ready", in_ready, 1'b0);
    tick();
    chk("rs_start", start_calc, 1'b1);
    chk("rs_coef0", coef[31:0], 32'hDEADBEEF);
    chk("rs_coef1", coef[63:32], 32'h00000001);
    run_core(3);

    // Core never goes busy: timeout error 16 cycles after start_calc.
    send_frame(vecs[3].ch);
    tick();
    chk("to_start", start_calc, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("to_err_cycle", load_err, (k == 16));
    end
    send_frame(vecs[0].ch);
    chk("to_next_lat1", start_calc, 1'b0);
    tick();
    chk("to_next_start", start_calc, 1'b1);
    chk("to_next_coef0", coef[31:0], vecs[0].c0);
    chk("to_next_coef1", coef[63:32], vecs[0].c1);
    run_core(3);

    // Reset in the middle of a frame discards the partial frame.
    for (int i = 0; i < 5; i++) send(vecs[2].ch[i], (i == 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_coef", coef, 64'h0);
    chk("mr_ready", in_ready, 1'b1);
    chk("mr_start", start_calc, 1'b0);
    for (int i = 5; i < 8; i++) send(vecs[2].ch[i], 1'b0);
    chk("mr_tail_dropped", in_ready, 1'b1);
    tick();
    chk("mr_tail_no_start", start_calc, 1'b0);
    send_frame(vecs[1].ch);
    chk("mr_lat1", start_calc, 1'b0);
    tick();
    chk("mr_start_after", start_calc, 1'b1);
    chk("mr_coef0", coef[31:0], vecs[1].c0);
    chk("mr_coef1", coef[63:32], vecs[1].c1);
    run_core(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_loader_n.md
PARAM_LOADER_N -- requirements
Module: param_loader_n

Interface
REQ-001 SHALL have parameter NUM_COEF, default 2, number of coefficients per frame (1..16).
REQ-002 SHALL have parameter COEF_W, default 32, coefficient width; an exact multiple of IN_W.
REQ-003 SHALL have parameter IN_W, default 8, input chunk width; CHUNKS = COEF_W/IN_W.
REQ-004 SHALL have parameter BUSY_TO, default 15, max cycles from start_calc to core_busy rising.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_data  in  IN_W  coefficient chunk.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_sof  in  1  chunk is chunk 0 of coefficient 0; qualified by in_valid.
REQ-011 in_ready  out  1  chunk accepted when in_valid && in_ready.
REQ-012 coef  out  NUM_COEF*COEF_W  active coefficients; coefficient k at bits [k*COEF_W +: COEF_W], two's complement.
REQ-013 start_calc  out  1  one-cycle start pulse to core.
REQ-014 core_busy  in  1  core computing; falling edge = done.
REQ-015 load_err  out  1  one-cycle error pulse.

Function
REQ-016 SHALL assemble chunks little-endian: first chunk of a coefficient -> bits [IN_W-1:0]; coefficients in index order 0..NUM_COEF-1.
REQ-017 SHALL accept chunks only with in_sof on the first chunk; chunks without in_sof while no frame is open are dropped, in_ready stays 1, no error.
REQ-018 SHALL write the frame into a shadow buffer; the frame completes on the cycle its NUM_COEF*CHUNKS-th chunk is accepted, setting pending next cycle.
REQ-019 SHALL drive in_ready = !pending (combinational on registered state); loading continues while the core is busy (double buffering).
REQ-020 SHALL restart the frame on in_sof arriving mid-frame: the in_sof chunk becomes chunk 0, load_err pulses the next cycle.
REQ-021 Control FSM states: S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE.
REQ-022 S_IDLE: if pending and !core_busy -> coef <= shadow, pending <= 0, start_calc <= 1, go S_START (commit and pulse on same registered edge).
REQ-023 S_START: start_calc <= 0; go S_WAIT_BUSY, timeout counter cleared.
REQ-024 S_WAIT_BUSY: core_busy=1 -> S_WAIT_DONE; counter reaches BUSY_TO with core_busy=0 -> load_err pulse, S_IDLE.
REQ-025 S_WAIT_DONE: core_busy=0 -> S_IDLE; an already-pending frame commits on the next S_IDLE cycle, giving 2 cycles busy-fall-to-next-start_calc.
REQ-026 Latency from last-chunk acceptance to start_calc with core idle SHALL be 2 cycles.
REQ-027 coef SHALL change only on commit; start_calc SHALL never be high two consecutive cycles.
REQ-028 A frame completing on the same cycle as a commit SHALL not be possible: pending blocks acceptance; shadow writes never overlap commit.
REQ-029 load_err pulses from REQ-020 and REQ-024 on the same cycle SHALL merge into one pulse.

Reset
REQ-030 rst SHALL clear coef to 0, start_calc 0, load_err 0, pending 0, frame counters 0, FSM to S_IDLE; in_ready 1 on the first cycle after reset.
REQ-031 rst mid-frame SHALL discard the partial frame; rst mid-calc SHALL abandon the handshake without start_calc.

Structure
REQ-032 The FSM state typedef, default parameter values and the little-endian chunk-order constant SHALL live in watchdog_pkg.
REQ-033 Chunk counting and shadow assembly SHALL be a sub-module param_assembler; the FSM and commit remain in param_loader_n.

Verification (NUM_COEF=2, COEF_W=32, IN_W=8, BUSY_TO=15)
REQ-034 Frame 0x78,56,34,12,0xF0,FF,FF,FF, core idle -> start_calc 2 cycles after last chunk; coef[31:0]=0x12345678, coef[63:32]=0xFFFFFFF0 (-16).
REQ-035 Core holds busy 20 cycles; second frame sent during busy -> in_ready 0 after it; coef unchanged until busy falls; start_calc 2 cycles after fall.
REQ-036 in_sof on 4th chunk -> load_err pulse; frame completes 8 chunks later from restart chunk; no start before that.
REQ-037 core_busy never rises after start_calc -> load_err 16 cycles later, FSM S_IDLE, next frame starts normally.
REQ-038 rst asserted after 5 chunks -> coef 0, in_ready 1; following full frame loads correctly.
